// File: rtl/control_unit.sv
// Multi-cycle control FSM for the 16-bit accumulator CPU: sequences fetch, decode,
// execute, memory access and reg_file write-back, one instruction at a time.
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       flag_z,
    input  logic       flag_n,
    input  logic       mem_ready,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       addr_sel,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [1:0] alu_op,
    output logic       acc_load,
    output logic       acc_src,
    output logic       rw,
    output logic       lse,
    output logic       ldm,
    output logic       lacc,
    output logic       halted,
    output logic       illegal
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_LDA  = 6'h01;
    localparam logic [5:0] OP_STA  = 6'h02;
    localparam logic [5:0] OP_ADD  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h06;
    localparam logic [5:0] OP_MOV  = 6'h07;
    localparam logic [5:0] OP_MOVI = 6'h08;
    localparam logic [5:0] OP_LDR  = 6'h09;
    localparam logic [5:0] OP_BRZ  = 6'h0A;
    localparam logic [5:0] OP_BRN  = 6'h0B;
    localparam logic [5:0] OP_BRA  = 6'h0C;
    localparam logic [5:0] OP_HLT  = 6'h3F;

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       is_alu;

    assign is_alu = (op_q >= OP_ADD) && (op_q <= OP_OR);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_MOV, OP_MOVI:        state_d = S_WB;
                    OP_LDA, OP_STA, OP_LDR: state_d = S_MEM;
                    OP_HLT:                 state_d = S_HALT;
                    default:                state_d = S_EXEC;
                endcase
            end
            S_EXEC:   state_d = S_FETCH;
            S_MEM:    if (mem_ready) state_d = (op_q == OP_LDR) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Outputs decode state and op_q combinationally; reset masks everything at once.
    always_comb begin
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        addr_sel = 1'b0;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        alu_op   = 2'b00;
        acc_load = 1'b0;
        acc_src  = 1'b0;
        rw       = 1'b0;
        lse      = 1'b0;
        ldm      = 1'b0;
        lacc     = 1'b0;
        halted   = 1'b0;
        illegal  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_rd  = 1'b1;
                    ir_load = mem_ready;
                    pc_inc  = mem_ready;
                end
                S_DECODE: ;
                S_EXEC: begin
                    if (is_alu) begin
                        alu_op   = 2'(op_q - OP_ADD);
                        acc_load = 1'b1;
                    end else begin
                        case (op_q)
                            OP_BRZ:  pc_load = flag_z;
                            OP_BRN:  pc_load = flag_n;
                            OP_BRA:  pc_load = 1'b1;
                            OP_NOP:  ;
                            default: illegal = 1'b1;
                        endcase
                    end
                end
                S_MEM: begin
                    addr_sel = 1'b1;
                    mem_wr   = (op_q == OP_STA);
                    mem_rd   = (op_q == OP_LDA) || (op_q == OP_LDR);
                    if (op_q == OP_LDA && mem_ready) begin
                        acc_src  = 1'b1;
                        acc_load = 1'b1;
                    end
                end
                S_WB: begin
                    rw   = 1'b1;
                    lacc = (op_q == OP_MOV);
                    lse  = (op_q == OP_MOVI);
                    ldm  = (op_q == OP_LDR);
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, reset/halt sequences,
// and random instruction streams checked cycle by cycle against an instruction-level model.
module tb_control_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       flag_z = 1'b0, flag_n = 1'b0, mem_ready = 1'b0;
    logic       mem_rd, mem_wr, addr_sel, ir_load, pc_inc, pc_load;
    logic [1:0] alu_op;
    logic       acc_load, acc_src, rw, lse, ldm, lacc, halted, illegal;

    int tests = 0;
    int fails = 0;

    // Output vector bit layout used for all expectations.
    localparam logic [15:0] RD   = 16'h8000, WR  = 16'h4000, AS  = 16'h2000, IRL = 16'h1000;
    localparam logic [15:0] PCI  = 16'h0800, PCL = 16'h0400, ACL = 16'h0080, ACS = 16'h0040;
    localparam logic [15:0] RW   = 16'h0020, LSE = 16'h0010, LDM = 16'h0008, LAC = 16'h0004;
    localparam logic [15:0] HLT  = 16'h0002, ILL = 16'h0001;

    control_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .flag_z(flag_z), .flag_n(flag_n),
        .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .alu_op(alu_op),
        .acc_load(acc_load), .acc_src(acc_src), .rw(rw), .lse(lse), .ldm(ldm),
        .lacc(lacc), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [15:0] act;
    assign act = {mem_rd, mem_wr, addr_sel, ir_load, pc_inc, pc_load, alu_op,
                  acc_load, acc_src, rw, lse, ldm, lacc, halted, illegal};

    // One cycle: inputs already driven; sample mid-cycle, then advance past the edge.
    task automatic cyc(input logic [15:0] exp, input string nm);
        logic ok_inv;
        @(negedge clk);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
        ok_inv = ($countones({lse, ldm, lacc}) <= 1) && (!(lse | ldm | lacc) || rw)
                 && !(mem_rd && mem_wr) && !(pc_inc && pc_load);
        tests++;
        if (ok_inv !== 1'b1) begin
            fails++;
            $display("FAIL invariant@%s: got %h expected 1", nm, ok_inv);
        end
        @(posedge clk);
        #1;
    endtask

    // Instruction-level model: expected outputs derived from the opcode's class.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input logic fz, input logic fn);
        logic [15:0] req, e;
        flag_z = fz;
        flag_n = fn;
        for (int i = 0; i < fw; i++) begin
            mem_ready = 1'b0; opcode = 6'($urandom);
            cyc(RD, "fetch_wait");
        end
        mem_ready = 1'b1;
        cyc(RD | IRL | PCI, "fetch");
        opcode = op; mem_ready = 1'($urandom);
        cyc(16'h0, "decode");
        opcode = 6'($urandom);  // decode must have captured op already
        if (op == 6'h3F) begin
            for (int i = 0; i < 10; i++) begin
                mem_ready = 1'($urandom);
                cyc(HLT, "halt");
            end
        end else if (op == 6'h01 || op == 6'h02 || op == 6'h09) begin
            req = AS | ((op == 6'h02) ? WR : RD);
            for (int i = 0; i < mw; i++) begin
                mem_ready = 1'b0;
                cyc(req, "mem_wait");
            end
            mem_ready = 1'b1;
            cyc(req | ((op == 6'h01) ? (ACL | ACS) : 16'h0), "mem");
            if (op == 6'h09) begin
                mem_ready = 1'($urandom);
                cyc(RW | LDM, "wb_ldr");
            end
        end else if (op == 6'h07 || op == 6'h08) begin
            mem_ready = 1'($urandom);
            cyc(RW | ((op == 6'h07) ? LAC : LSE), "wb");
        end else begin
            mem_ready = 1'($urandom);
            if (op >= 6'h03 && op <= 6'h06) e = {6'd0, 2'(op - 6'd3), 8'h00} | ACL;
            else if (op == 6'h0A)           e = fz ? PCL : 16'h0;
            else if (op == 6'h0B)           e = fn ? PCL : 16'h0;
            else if (op == 6'h0C)           e = PCL;
            else if (op == 6'h00)           e = 16'h0;
            else                            e = ILL;
            cyc(e, "exec");
        end
    endtask

    typedef struct {
        logic [5:0]  op;
        logic        fz, fn;
        int          lat;
        logic [15:0] last;
    } vec_t;

    vec_t vt[15];
    logic [5:0] rops[16];

    initial begin
        vt[0]  = '{6'h00, 1'b0, 1'b0, 3, 16'h0};
        vt[1]  = '{6'h03, 1'b1, 1'b1, 3, ACL};
        vt[2]  = '{6'h04, 1'b0, 1'b0, 3, 16'h0100 | ACL};
        vt[3]  = '{6'h06, 1'b0, 1'b0, 3, 16'h0300 | ACL};
        vt[4]  = '{6'h01, 1'b0, 1'b0, 3, AS | RD | ACL | ACS};
        vt[5]  = '{6'h02, 1'b0, 1'b0, 3, AS | WR};
        vt[6]  = '{6'h09, 1'b0, 1'b0, 4, RW | LDM};
        vt[7]  = '{6'h07, 1'b0, 1'b0, 3, RW | LAC};
        vt[8]  = '{6'h08, 1'b0, 1'b0, 3, RW | LSE};
        vt[9]  = '{6'h0A, 1'b1, 1'b0, 3, PCL};
        vt[10] = '{6'h0A, 1'b0, 1'b1, 3, 16'h0};
        vt[11] = '{6'h0B, 1'b0, 1'b1, 3, PCL};
        vt[12] = '{6'h0C, 1'b0, 1'b0, 3, PCL};
        vt[13] = '{6'h20, 1'b1, 1'b1, 3, ILL};
        vt[14] = '{6'h0D, 1'b0, 1'b0, 3, ILL};
        rops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h20, 6'h15, 6'h3E};

        // Reset state, then first post-reset cycle is a fetch request.
        mem_ready = 1'b1;
        cyc(16'h0, "reset0");
        cyc(16'h0, "reset1");
        rst = 1'b0; mem_ready = 1'b0;
        cyc(RD, "post_reset");

        // Reset in the middle of a held LDR memory read.
        mem_ready = 1'b1;
        cyc(RD | IRL | PCI, "mr_fetch");
        opcode = 6'h09;
        cyc(16'h0, "mr_decode");
        mem_ready = 1'b0;
        cyc(AS | RD, "mr_mem_wait");
        rst = 1'b1; mem_ready = 1'b1;
        cyc(16'h0, "mr_rst0");
        cyc(16'h0, "mr_rst1");
        rst = 1'b0; mem_ready = 1'b0;
        cyc(RD, "mr_post_reset");

        // Directed table with mem_ready tied high; each fetch also confirms prior latency.
        foreach (vt[k]) begin
            mem_ready = 1'b1; opcode = 6'($urandom);
            cyc(RD | IRL | PCI, "tbl_fetch");
            opcode = vt[k].op; flag_z = vt[k].fz; flag_n = vt[k].fn;
            for (int c = 1; c < vt[k].lat; c++) begin
                if (c == vt[k].lat - 1) cyc(vt[k].last, $sformatf("tbl_last_op%0h", vt[k].op));
                else if (c == 1)        cyc(16'h0, "tbl_decode");
                else                    cyc(AS | RD, "tbl_mid");
                opcode = 6'($urandom);
            end
        end

        // LDR with two wait states in MEM.
        run_instr(6'h09, 1, 2, 1'b0, 1'b0);

        // Random instruction stream with random memory waits and flags.
        for (int n = 0; n < 80; n++)
            run_instr(rops[$urandom_range(15)], $urandom_range(2), $urandom_range(2),
                      1'($urandom), 1'($urandom));

        // Halt holds with no fetch until reset.
        run_instr(6'h3F, 0, 0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(16'h0, "halt_rst");
        rst = 1'b0; mem_ready = 1'b0;
        cyc(RD, "halt_post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle control FSM for the 16-bit accumulator CPU. It sits directly upstream of `reg_file` and drives that block's write strobe `rw` and its one-hot source selects `lse`, `ldm` and `lacc`. It also sequences instruction fetch, the ALU/accumulator, the PC, and the memory handshake. One instruction is in flight at a time; there is no pipelining.

## Interface
- No parameters; widths are fixed by the ISA.
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- opcode  in  6  instruction bits [15:10] from the external IR; valid from DECODE onward
- flag_z  in  1  accumulator zero flag
- flag_n  in  1  accumulator negative flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_rd, mem_wr  out  1  memory read / write request, held until mem_ready
- addr_sel  out  1  memory address source: 0 = PC, 1 = IR operand
- ir_load  out  1  load IR from memory data
- pc_inc, pc_load  out  1  PC+1 / PC ← IR operand
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR
- acc_load  out  1  accumulator write enable
- acc_src  out  1  accumulator source: 0 = ALU, 1 = memory data
- rw, lse, ldm, lacc  out  1 each  `reg_file` write enable and source selects (immediate / memory / accumulator)
- halted  out  1  core stopped
- illegal  out  1  one-cycle pulse on an undefined opcode

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT; 3-bit encoding.
- All outputs are a combinational decode of the current state and `op_q`. `op_q` is the 6-bit opcode latched in DECODE.
- **FETCH:** `mem_rd=1`, `addr_sel=0`. When `mem_ready=1`: `ir_load=1`, `pc_inc=1`, next state DECODE. Otherwise stay in FETCH.
- **DECODE:** latch `op_q←opcode`. Next state by opcode:
  - MOV, MOVI → WB
  - LDA, STA, LDR → MEM
  - HLT → HALT
  - all other opcodes → EXEC
- **Opcodes:**
  - 0x00 NOP
  - 0x01 LDA: acc←mem
  - 0x02 STA: mem←acc
  - 0x03 ADD, 0x04 SUB, 0x05 AND, 0x06 OR
  - 0x07 MOV: reg←acc
  - 0x08 MOVI: reg←se
  - 0x09 LDR: reg←mem
  - 0x0A BRZ, 0x0B BRN, 0x0C BRA
  - 0x3F HLT
  - any other value is illegal
- **EXEC:**
  - ALU opcodes: `alu_op=opcode-3`, `acc_src=0`, `acc_load=1`.
  - BRZ: `pc_load=flag_z`. BRN: `pc_load=flag_n`. BRA: `pc_load=1`.
  - NOP and illegal opcodes: no strobes. Illegal additionally gives `illegal=1` for this single cycle.
  - Next state always FETCH.
- **MEM:** `addr_sel=1`.
  - STA: `mem_wr=1`.
  - LDA, LDR: `mem_rd=1`.
  - On `mem_ready=1`:
    - LDA: `acc_src=1`, `acc_load=1` in the same cycle, then FETCH.
    - STA: go to FETCH.
    - LDR: go to WB.
  - Without `mem_ready`, stay in MEM with the request held.
- **WB:** `rw=1` with exactly one select: MOV→`lacc`, MOVI→`lse`, LDR→`ldm`. Next state FETCH.
- **HALT:** `halted=1`; all other outputs 0. Only `rst` leaves this state.
- **Invariants:**
  - At most one of `lse/ldm/lacc` is 1, and a select is 1 only when `rw=1`.
  - `mem_rd` and `mem_wr` are never both 1.
  - `pc_inc` and `pc_load` are never both 1.

## Timing
- **Reset:** while `rst=1`, every output is forced to 0 combinationally. At the next edge, state←FETCH and `op_q←0`.
- In the first cycle after `rst` falls, `mem_rd=1` and `addr_sel=0`.
- **Reset mid-operation:** a pending `mem_rd`/`mem_wr` drops in the same cycle `rst` rises. `mem_ready` seen during reset is ignored. No partial `rw`/`acc_load` is issued.
- **Latency with `mem_ready` tied to 1:**
  - NOP, ALU and branch: 3 cycles
  - MOV and MOVI: 3 cycles (FETCH, DECODE, WB)
  - LDA and STA: 3 cycles
  - LDR: 4 cycles
  - Each memory wait cycle adds 1.
- **Handshake:**
  - A request stays asserted, with `addr_sel` stable, until the cycle in which `mem_ready=1`. It deasserts the following cycle.
  - `mem_ready` is ignored outside FETCH and MEM.
- **Branch semantics:** `pc_inc` has already occurred in FETCH. `pc_load` in EXEC overrides the incremented PC, and the branch target takes effect in the next FETCH.
- **Flag timing:** `flag_z`/`flag_n` are sampled in EXEC and reflect the accumulator before this instruction.

## Test plan
- **Reset:** `rst=1` for 2 cycles in mid-MEM with `mem_rd=1` → all outputs 0 during reset; first post-reset cycle shows `mem_rd=1`, `addr_sel=0`.
- **MOVI write-back:** opcode 0x08, `mem_ready=1` → cycle 3 shows `rw=1`, `lse=1`, `ldm=0`, `lacc=0`; next cycle is FETCH.
- **Write-back sources, one per case:**
  - MOV (0x07) → cycle 3 shows `rw=1` with `lacc=1`, `lse=0`, `ldm=0`.
  - LDR (0x09) with `mem_ready` low for 2 MEM cycles → `mem_rd` and `addr_sel=1` held 3 cycles; then WB with `rw=1`, `ldm=1`, `lse=0`, `lacc=0`.
  - Checkers confirm the one-hot invariant on every cycle of the run.
- **ALU/LDA:** ADD (0x03) → EXEC cycle shows `alu_op=00`, `acc_load=1`, `acc_src=0`. LDA (0x01) with `mem_ready=1` → MEM cycle shows `acc_load=1`, `acc_src=1`.
- **Branches:**
  - BRZ with `flag_z=1` → `pc_load=1` in EXEC.
  - BRZ with `flag_z=0` → `pc_load=0` in EXEC.
  - BRA → `pc_load=1` regardless of flags.
- **Illegal/halt:**
  - Opcode 0x20 → `illegal=1` for exactly one cycle; no strobes; next state FETCH.
  - Opcode 0x3F → `halted=1` stays set and no further `mem_rd` is issued for 10 cycles until `rst`.
